// File: rtl/lbus_pkg.sv
// Shared types and defaults for the local-bus initiator.
package lbus_pkg;
  localparam int LBUS_DW = 16;
  localparam int LBUS_AW = 16;
  localparam int CNT_W   = 8;

  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_ACK_TIMEOUT  = 255;
  localparam int DEF_GAP_CYCLES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_GAP
  } lbus_state_t;

  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction
endpackage

// File: rtl/lbus_ack_sync.sv
// Two-flop synchronizer for the slave Ack with a rising-edge detect.
module lbus_ack_sync (
  input  logic CLK_32,
  input  logic RESET,
  input  logic ack_async,
  output logic ack_s,
  output logic ack_rise
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge CLK_32) begin
    if (RESET) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= ack_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign ack_s    = sync_q;
  assign ack_rise = sync_q & ~prev_q;
endmodule

// File: rtl/lbus_master_ctrl.sv
// Local-bus initiator: single read/write cycles with level Ack, timeout and
// inter-transaction gap. All bus and response outputs are registered.
module lbus_master_ctrl
  import lbus_pkg::*;
#(
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic               CLK_32,
  input  logic               RESET,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [LBUS_AW-1:0] cmd_addr,
  input  logic [LBUS_DW-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [LBUS_DW-1:0] rsp_rdata,
  output logic               rsp_err,
  inout  wire  [LBUS_DW-1:0] LBUS_DAT,
  output logic [LBUS_AW-1:0] LBUS_ADR,
  output logic               LBUS_CYC_N,
  output logic               LBUS_STB_N,
  output logic               LBUS_SEL_N,
  output logic               LBUS_WE,
  input  logic               LBUS_ACK
);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  lbus_state_t state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               strb_n_q, strb_n_d;
  logic               we_q, we_d;
  logic               oe_q, oe_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [LBUS_AW-1:0] adr_q, adr_d;
  logic [LBUS_DW-1:0] wdata_q, wdata_d;
  logic [LBUS_DW-1:0] cap_q, cap_d;
  logic [LBUS_DW-1:0] rsp_rdata_q, rsp_rdata_d;

  logic ack_s, ack_rise;
  logic accept, cnt_tmo, rel_fail;

  lbus_ack_sync u_ack_sync (
    .CLK_32    (CLK_32),
    .RESET     (RESET),
    .ack_async (LBUS_ACK),
    .ack_s     (ack_s),
    .ack_rise  (ack_rise)
  );

  assign accept   = (state_q == ST_IDLE) && cmd_valid && ready_q;
  assign cnt_tmo  = (cnt_q >= TMO_LAST);
  assign rel_fail = ack_s && cnt_tmo;

  always_ff @(posedge CLK_32) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Accepting only a rising edge means an Ack already high on STROBE entry
  // must drop at least once before it can complete the cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_SETUP;
      ST_SETUP:   if (cnt_q >= SETUP_LAST) state_d = ST_STROBE;
      ST_STROBE:  if (ack_rise || cnt_tmo) state_d = ST_RELEASE;
      ST_RELEASE: if (!ack_s || cnt_tmo) state_d = ST_GAP;
      ST_GAP:     if (cnt_q >= GAP_LAST) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = (state_d != state_q) ? '0 : cnt_inc_sat(cnt_q);
    strb_n_d    = (state_d != ST_STROBE);
    ready_d     = (state_d == ST_IDLE);
    adr_d       = adr_q;
    we_d        = we_q;
    oe_d        = oe_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          adr_d   = cmd_addr;
          we_d    = cmd_we;
          oe_d    = cmd_we;
          wdata_d = cmd_wdata;
          err_d   = 1'b0;
          cap_d   = '0;
        end
      end
      ST_STROBE: begin
        if (ack_rise) begin
          if (!we_q) cap_d = LBUS_DAT;
        end else if (cnt_tmo) begin
          err_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ack_s || cnt_tmo) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q | rel_fail;
          rsp_rdata_d = (err_q || rel_fail) ? '0 : cap_q;
          oe_d        = 1'b0;
          we_d        = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_32) begin
    if (RESET) begin
      cnt_q       <= '0;
      strb_n_q    <= 1'b1;
      ready_q     <= 1'b0;
      adr_q       <= '0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      strb_n_q    <= strb_n_d;
      ready_q     <= ready_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign LBUS_DAT   = oe_q ? wdata_q : 'z;
  assign LBUS_ADR   = adr_q;
  assign LBUS_WE    = we_q;
  assign LBUS_CYC_N = strb_n_q;
  assign LBUS_STB_N = strb_n_q;
  assign LBUS_SEL_N = strb_n_q;
  assign cmd_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
endmodule
